sync_fifo_ctrl: RTL and testbench

- Parametrised single-clock FIFO. Next generation of the team's FIFO block.
- Generalised width, depth and thresholds.
- Adds an occupancy count, almost-full and almost-empty flags, sticky overflow/underflow error flags, and an optional first-word-fall-through (FWFT) read mode.
- Sits between producer/consumer stages inside one clock domain of the clock network, e.g. buffering clock-monitor samples after the CDC stage.

---
 rtl/fifo_pkg.sv | 22 ++
 rtl/fifo_mem.sv | 40 ++++
 rtl/sync_fifo_ctrl.sv | 139 +++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and defaults for the synchronous FIFO family.
package fifo_pkg;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_DEPTH     = 16;
  localparam int unsigned DEF_AE_THRESH = 2;

  // Pointer width: address bits plus one wrap bit.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write, registered read with a load-through path.
module fifo_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  input  logic                       byp_en,
  input  logic [WIDTH-1:0]           byp_data,
  output logic [WIDTH-1:0]           rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;
  logic [WIDTH-1:0] rd_data_d;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  // Load-through lets a word skip the array when it goes straight to the output.
  always_comb begin
    rd_data_d = rd_data_q;
    if (byp_en)     rd_data_d = byp_data;
    else if (rd_en) rd_data_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock FIFO with occupancy count, threshold flags and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read mode.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = DEF_AE_THRESH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          data_in,
  input  logic                      wr_en,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          data_out,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [ptr_w(DEPTH)-1:0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned AW = PW - 1;

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || WIDTH < 1 ||
      AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH) begin : g_param_check
    $error("sync_fifo_ctrl: illegal WIDTH/DEPTH/threshold parameters");
  end

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  fifo_status_t  status_q, status_d;
  logic          wr_accept, rd_accept;
  logic          mem_we, mem_re, byp_en;

`ifdef SYNC_FIFO_FWFT_EN
  logic valid_q, valid_d;
  logic load, mem_empty;
`endif

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    status_d  = status_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    byp_en    = 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
    valid_d   = valid_q;
    // The output register is the head; the array holds everything behind it.
    rd_accept = rd_en && valid_q;
    wr_accept = wr_en && (!status_q.full || rd_accept);
    load      = !valid_q || rd_accept;
    mem_empty = (wr_ptr_q == rd_ptr_q);
    if (load && !mem_empty) begin
      mem_re   = 1'b1;
      rd_ptr_d = rd_ptr_q + PW'(1);
      valid_d  = 1'b1;
    end else if (load && wr_accept) begin
      byp_en   = 1'b1;
      valid_d  = 1'b1;
    end else if (rd_accept) begin
      valid_d  = 1'b0;
    end
    mem_we = wr_accept && !byp_en;
    if (mem_we) wr_ptr_d = wr_ptr_q + PW'(1);
    count_d        = count_q + PW'(wr_accept) - PW'(rd_accept);
    status_d.empty = !valid_d;
    status_d.full  = (count_d == PW'(DEPTH));
`else
    rd_accept = rd_en && !status_q.empty;
    wr_accept = wr_en && (!status_q.full || rd_accept);
    mem_re    = rd_accept;
    mem_we    = wr_accept;
    if (mem_re) rd_ptr_d = rd_ptr_q + PW'(1);
    if (mem_we) wr_ptr_d = wr_ptr_q + PW'(1);
    count_d        = count_q + PW'(wr_accept) - PW'(rd_accept);
    status_d.empty = (wr_ptr_d == rd_ptr_d);
    status_d.full  = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) &&
                     (wr_ptr_d[AW] != rd_ptr_d[AW]);
`endif
    status_d.almost_full  = (32'(count_d) >= AF_THRESH);
    status_d.almost_empty = (32'(count_d) <= AE_THRESH);
    status_d.overflow     = status_q.overflow  | (wr_en & ~wr_accept);
    status_d.underflow    = status_q.underflow | (rd_en & ~rd_accept);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      status_q <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0,
                    almost_empty: 1'b1, overflow: 1'b0, underflow: 1'b0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      status_q <= status_d;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  always_ff @(posedge clk) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_d;
  end
`endif

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (mem_we),
    .wr_addr  (wr_ptr_q[AW-1:0]),
    .wr_data  (data_in),
    .rd_en    (mem_re),
    .rd_addr  (rd_ptr_q[AW-1:0]),
    .byp_en   (byp_en),
    .byp_data (data_in),
    .rd_data  (data_out)
  );

  assign count        = count_q;
  assign full         = status_q.full;
  assign empty        = status_q.empty;
  assign almost_full  = status_q.almost_full;
  assign almost_empty = status_q.almost_empty;
  assign overflow     = status_q.overflow;
  assign underflow    = status_q.underflow;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Scoreboard bench for sync_fifo_ctrl against a queue-based reference model.
module tb_sync_fifo_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF    = 14;
  localparam int unsigned AE    = 2;
  localparam int unsigned CW    = 5;

  logic             clk = 1'b0;
  logic             rst, wr_en, rd_en;
  logic [WIDTH-1:0] data_in, data_out;
  logic             full, empty, almost_full, almost_empty, overflow, underflow;
  logic [CW-1:0]    count;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] model_q [$];
  logic [WIDTH-1:0] exp_q   [$];
  logic [WIDTH-1:0] last_out;
  bit               m_ovf, m_unf;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a FIFO is a queue; accept rules follow the occupancy alone.
  task automatic model_step(input bit w, input bit r, input logic [WIDTH-1:0] d, input bit rs);
    bit ra, wa;
    logic [WIDTH-1:0] v;
    if (rs) begin
      model_q.delete();
      m_ovf    = 1'b0;
      m_unf    = 1'b0;
      last_out = '0;
    end else begin
      ra = r && (model_q.size() > 0);
      wa = w && ((model_q.size() < DEPTH) || ra);
      if (r && !ra) m_unf = 1'b1;
      if (w && !wa) m_ovf = 1'b1;
      if (ra) begin
        v = model_q.pop_front();
        exp_q.push_back(v);
        last_out = v;
      end
      if (wa) model_q.push_back(d);
    end
  endtask

  task automatic check_state();
    int n;
    n = model_q.size();
    chk("count", int'(count), n);
    chk("full", int'(full), int'(n == DEPTH));
    chk("empty", int'(empty), int'(n == 0));
    chk("almost_full", int'(almost_full), int'(n >= AF));
    chk("almost_empty", int'(almost_empty), int'(n <= AE));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("underflow", int'(underflow), int'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
    chk("data_out", int'(data_out), int'((n > 0) ? model_q[0] : last_out));
`else
    chk("data_out", int'(data_out), int'(last_out));
`endif
  endtask

  task automatic step(input bit w, input bit r, input logic [WIDTH-1:0] d, input bit rs = 1'b0);
    wr_en   = w;
    rd_en   = r;
    data_in = d;
    rst     = rs;
    model_step(w, r, d, rs);
    @(posedge clk);
    #1;
    check_state();
  endtask

  // Monitor: compares every word the DUT hands over against the scoreboard.
  initial begin
    bit acc;
    logic [WIDTH-1:0] e;
    forever begin
      @(negedge clk);
      acc = rd_en && !empty && !rst;
`ifndef SYNC_FIFO_FWFT_EN
      @(posedge clk);
      #1;
`endif
      if (acc) begin
        chk("mon_exp_avail", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("mon_data", int'(data_out), int'(e));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int unsigned val;
    int unsigned wp, rp;
    rst      = 1'b1;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    data_in  = '0;
    last_out = '0;

    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Fill, then overflow.
    for (int i = 1; i <= 16; i++) step(1'b1, 1'b0, 8'(i));
    step(1'b1, 1'b0, 8'hFF);
    chk("ovf_after_17th", int'(overflow), 1);

    // Drain, then underflow.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'h00);
    chk("unf_after_extra", int'(underflow), 1);

    // Full with simultaneous read/write across pointer wrap.
    step(1'b0, 1'b0, 8'h00, 1'b1);
    val = 0;
    for (int i = 0; i < 16; i++) begin step(1'b1, 1'b0, 8'(val)); val++; end
    for (int i = 0; i < 40; i++) begin step(1'b1, 1'b1, 8'(val)); val++; end
    chk("hold_count", int'(count), 16);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00);

    // Simultaneous read/write at empty.
    step(1'b1, 1'b1, 8'hA5);
    chk("empty_rw_count", int'(count), 1);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    // Reset in the middle of a write burst.
    step(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h50 + i), i == 4);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h00);

`ifdef SYNC_FIFO_FWFT_EN
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h3C);
    chk("fwft_head", int'(data_out), 8'h3C);
    step(1'b0, 1'b1, 8'h00);
    chk("fwft_empty_after_pop", int'(empty), 1);
`endif

    // Randomized traffic with shifting write/read bias and rare resets.
    wp = 50;
    rp = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        wp = $urandom_range(90, 10);
        rp = $urandom_range(90, 10);
      end
      step($urandom_range(99, 0) < wp, $urandom_range(99, 0) < rp,
           8'($urandom), $urandom_range(499, 0) == 0);
    end

    for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
